// File: rtl/nebula_axi_line_writer_if.sv
// AXI4 write-only master bundle (AW/W/B) used by the cache-line write-back engine.
interface nebula_axi_line_writer_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4
);
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;
    logic [63:0]               wdata;
    logic [7:0]                wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/nebula_axi_line_writer.sv
// Write-back engine: one 512-bit line in, one 8-beat 64-bit AXI4 INCR burst out,
// single-cycle ack carrying the write response status.
module nebula_axi_line_writer #(
    parameter int unsigned             PADDR_WIDTH    = 56,
    parameter int unsigned             AXI_ADDR_WIDTH = 64,
    parameter int unsigned             AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_req,
    input  logic [PADDR_WIDTH-1:0] wr_addr,
    input  logic [511:0]           wr_data,
    output logic                   wr_ack,
    output logic                   wr_error,
    output logic                   busy,
    nebula_axi_line_writer_if.master m_axi
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP,
        ST_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [511:0]              line_q;
    logic [2:0]                beat_cnt;
    logic                      aw_done;
    logic                      w_done;
    logic                      error_q;

    logic aw_hs, w_hs, b_hs;
    logic aw_complete, w_complete;
    logic awvalid_c, wvalid_c, bready_c, ack_c, busy_c;

    // Ignored inputs: sub-line address bits and the response ID
    logic unused_inputs;
    assign unused_inputs = ^{wr_addr[5:0], m_axi.bid, m_axi.bresp[0]};

    assign aw_hs = awvalid_c & m_axi.awready;
    assign w_hs  = wvalid_c & m_axi.wready;
    assign b_hs  = bready_c & m_axi.bvalid;

    // Both channels may finish in the same cycle, so fold in this cycle's handshakes
    assign aw_complete = aw_done | aw_hs;
    assign w_complete  = w_done | (w_hs & (beat_cnt == 3'd7));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        bready_c  = 1'b0;
        ack_c     = 1'b0;
        busy_c    = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (wr_req) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                awvalid_c = ~aw_done;
                wvalid_c  = ~w_done;
                if (aw_complete && w_complete) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bready_c = 1'b1;
                if (m_axi.bvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_c     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            line_q   <= '0;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (state == ST_IDLE && wr_req) begin
                addr_q   <= AXI_ADDR_WIDTH'({wr_addr[PADDR_WIDTH-1:6], 6'b0});
                line_q   <= wr_data;
                beat_cnt <= '0;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            // Counter wraps to 0 after beat 7, which also clears wlast once W is done
            if (w_hs) begin
                beat_cnt <= beat_cnt + 3'd1;
                if (beat_cnt == 3'd7) begin
                    w_done <= 1'b1;
                end
            end
            if (b_hs) begin
                error_q <= m_axi.bresp[1];
            end
        end
    end

    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = 8'd7;
    assign m_axi.awsize  = 3'b011;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awvalid_c;
    assign m_axi.wdata   = line_q[{beat_cnt, 6'd0} +: 64];
    assign m_axi.wstrb   = 8'hFF;
    assign m_axi.wlast   = (beat_cnt == 3'd7);
    assign m_axi.wvalid  = wvalid_c;
    assign m_axi.bready  = bready_c;

    assign wr_ack   = ack_c;
    assign wr_error = error_q;
    assign busy     = busy_c;

endmodule
